// File: rtl/search_pkg.sv
// Shared types and constants for the pattern-search datapath.
// The log_state_t encoding is exported on the log_state pin, so keep it fixed.
package search_pkg;

    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOG   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } log_state_t;

endpackage

// File: rtl/match_fifo.sv
// Small FIFO holding match positions: it has a clear, and the head entry is
// presented combinationally from registered storage.
module match_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [W-1:0]  head_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is reset so rd_pos reads 0 straight out of reset; clear leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/match_logger.sv
// Match logger: records match positions during a search, counts matches (saturating),
// then drains the stored positions over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for first start after reset
// LOG   | search running, match positions are captured
// DRAIN | search over, stored positions handed out one per transfer
// DONE  | buffer empty, done held until next start
module match_logger
    import search_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             match_valid,
    input  logic [IDX_W-1:0] match_pos,
    input  logic             search_done,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_pos,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             done,
    output logic [1:0]       log_state
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    log_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic             log_match;

    match_fifo #(
        .W     (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (match_pos),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (rd_pos),
        .count_o (fifo_count)
    );

    assign log_match = (state_q == LOG) && match_valid;

    always_comb begin
        state_d   = state_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOG;
            end
            LOG: begin
                fifo_push = match_valid && !fifo_full;
                if (search_done) state_d = DRAIN;
            end
            DRAIN: begin
                rd_valid = !fifo_empty;
                fifo_pop = rd_valid && rd_ready;
                // Leave as soon as the last entry goes, so done rises the cycle after.
                if (fifo_empty || (fifo_pop && fifo_count == (AW+1)'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d   = LOG;
            fifo_push = 1'b0;
            fifo_pop  = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (start) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (log_match) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (fifo_full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign match_count = cnt_q;
    assign overflow    = ovf_q;
    assign log_state   = state_q;

endmodule

// File: tb/tb_match_logger.sv
// Scoreboard bench for match_logger: a default instance plus a CNT_W=3 instance
// sharing the same stimulus, so counter saturation is observed alongside normal runs.
module tb_match_logger;
    import search_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       match_valid = 1'b0;
    logic [7:0] match_pos = '0;
    logic       search_done = 1'b0;
    logic       rd_ready = 1'b0;

    logic       rd_valid, rd_valid_s;
    logic [7:0] rd_pos, rd_pos_s;
    logic [7:0] match_count;
    logic [2:0] match_count_s;
    logic       overflow, overflow_s;
    logic       done, done_s;
    logic [1:0] log_state, log_state_s;

    int n_checks = 0;
    int n_errors = 0;

    int  sb[$];
    bit  m_log   = 1'b0;
    bit  m_drain = 1'b0;
    int  m_cnt   = 0;
    int  m_cnt3  = 0;
    bit  m_ovf   = 1'b0;

    always #5 clk = ~clk;

    match_logger dut (
        .clk(clk), .rst(rst), .start(start), .match_valid(match_valid),
        .match_pos(match_pos), .search_done(search_done), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pos(rd_pos), .match_count(match_count),
        .overflow(overflow), .done(done), .log_state(log_state)
    );

    match_logger #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .start(start), .match_valid(match_valid),
        .match_pos(match_pos), .search_done(search_done), .rd_ready(rd_ready),
        .rd_valid(rd_valid_s), .rd_pos(rd_pos_s), .match_count(match_count_s),
        .overflow(overflow_s), .done(done_s), .log_state(log_state_s)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        m_cnt  = 0;
        m_cnt3 = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_match(input int pos);
        if (m_log) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt3 < 7) m_cnt3++;
            if (sb.size() < 8) sb.push_back(pos);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        model_clear();
        m_log   = 1'b1;
        m_drain = 1'b0;
    endtask

    task automatic do_match(input int pos);
        match_valid = 1'b1;
        match_pos   = 8'(pos);
        cyc();
        match_valid = 1'b0;
        model_match(pos);
    endtask

    task automatic end_search(input bit with_match, input int pos);
        search_done = 1'b1;
        match_valid = with_match;
        match_pos   = 8'(pos);
        cyc();
        search_done = 1'b0;
        match_valid = 1'b0;
        if (with_match) model_match(pos);
        if (m_log) begin
            m_log   = 1'b0;
            m_drain = 1'b1;
        end
    endtask

    task automatic drain_wait(input bit toggle, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            rd_ready = toggle ? ~rd_ready : 1'b1;
            cyc();
            ncyc++;
        end
        rd_ready = 1'b0;
        check("drain_timeout", done, 1);
        check("sb_left", sb.size(), 0);
        m_drain = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_count"}, match_count, m_cnt);
        check({tag, "_count_s"}, match_count_s, m_cnt3);
        check({tag, "_ovf"}, overflow, m_ovf);
    endtask

    // Transfers happen on the next rising edge; start suppresses them.
    always @(negedge clk) begin
        if (rst) begin
            check("rd_valid", rd_valid, (m_drain && sb.size() > 0) ? 1 : 0);
            if (!start && rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    check("rd_extra", sb.size(), 1);
                end else begin
                    int exp_pos;
                    exp_pos = sb.pop_front();
                    check("rd_pos", rd_pos, exp_pos);
                    check("rd_pos_s", rd_pos_s, exp_pos);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        #12;
        check("rst_state", log_state, 0);
        check("rst_rd_pos", rd_pos, 0);
        check_counts("rst");
        rst = 1'b1;
        cyc();

        // Match while IDLE is ignored.
        do_match(5);
        check("idle_ignore", match_count, 0);
        check("idle_state", log_state, 0);

        // Reset mid-LOG with 3 entries.
        do_start();
        do_match(1); do_match(2); do_match(3);
        check("log_state", log_state, 1);
        check("log_count", match_count, 3);
        #1 rst = 1'b0;
        model_clear();
        m_log = 1'b0;
        #1;
        check("arst_state", log_state, 0);
        check("arst_count", match_count, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_pos", rd_pos, 0);
        check("arst_done", done, 0);
        check("arst_ovf", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc();

        // Basic run: three matches drained on consecutive cycles.
        do_start();
        do_match(4); do_match(9); do_match(17);
        end_search(1'b0, 0);
        check("drain_state", log_state, 2);
        drain_wait(1'b0, n);
        check("drain_cycles", n, 3);
        check("done_state", log_state, 3);
        check_counts("basic");
        do_match(40);
        check("done_ignore", match_count, 3);
        check("done_held", done, 1);

        // Overflow: ten matches into eight slots.
        do_start();
        check("restart_done", done, 0);
        for (int i = 0; i < 10; i++) do_match(i);
        end_search(1'b0, 0);
        check_counts("ovf");
        drain_wait(1'b0, n);
        check_counts("ovf_end");

        // Match coincident with search_done is the last entry.
        do_start();
        do_match(30); do_match(31);
        end_search(1'b1, 22);
        check_counts("coinc");
        drain_wait(1'b0, n);
        check("coinc_cycles", n, 3);

        // Start mid-DRAIN with two entries left.
        do_start();
        for (int i = 0; i < 4; i++) do_match(50 + i);
        end_search(1'b0, 0);
        rd_ready = 1'b1;
        cyc(); cyc();
        rd_ready = 1'b0;
        check("pre_restart_state", log_state, 2);
        do_start();
        check("restart_rd_valid", rd_valid, 0);
        check("restart_state", log_state, 1);
        check_counts("restart");
        end_search(1'b0, 0);
        drain_wait(1'b0, n);
        check("empty_drain_state", log_state, 3);

        // Saturating count on narrow instance, with gapped ready.
        do_start();
        for (int i = 0; i < 9; i++) do_match(100 + i);
        end_search(1'b0, 0);
        check_counts("sat");
        drain_wait(1'b1, n);
        check_counts("sat_end");
        check("sat_done_s", done_s, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
